// File: rtl/pipealu_param.sv
// pipealu_param: two-stage ALU pipeline with internal register file and in_valid/in_ready handshake.
// Build option: define PIPEALU_PARAM_FWD_EN to forward the S1 result instead of stalling on RAW hazards.
`default_nettype none

module pipealu_param #(
    parameter int WIDTH = 32,
    parameter int AW    = 4,
    localparam int NREG = 2**AW,
    localparam int IW   = 4 + 3*AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    instr,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] AluOut,
    output logic [AW-1:0]    out_rd,
    output logic             Zero,
    output logic             Carryout,
    output logic             Overflow
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    logic [WIDTH-1:0] regs_q [NREG];
    logic             rdy_q;
    logic             s1_vld_q;
    logic [3:0]       s1_op_q;
    logic [AW-1:0]    s1_rd_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             vld_q, z_q, c_q, o_q;
    logic [WIDTH-1:0] res_q;
    logic [AW-1:0]    rd_q;

    logic [3:0]       op_in;
    logic [AW-1:0]    rs_in, rt_in, rd_in;
    logic [WIDTH-1:0] a_d, b_d, res_d, b_eff;
    logic [WIDTH:0]   sum;
    logic             is_sub, ovf, legal, cy_d, ov_d, z_d, wb_en, accept;

    assign op_in = instr[IW-1 -: 4];
    assign rs_in = instr[3*AW-1 -: AW];
    assign rt_in = instr[2*AW-1 -: AW];
    assign rd_in = instr[AW-1:0];

    // SUB and SLT share the adder as A + ~B + 1.
    always_comb begin
        is_sub = (s1_op_q == c_OP_SUB) || (s1_op_q == c_OP_SLT);
        b_eff  = is_sub ? ~s1_b_q : s1_b_q;
        sum    = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        ovf    = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
        res_d  = '0;
        cy_d   = 1'b0;
        ov_d   = 1'b0;
        legal  = 1'b1;
        case (s1_op_q)
            c_OP_AND: res_d = s1_a_q & s1_b_q;
            c_OP_OR:  res_d = s1_a_q | s1_b_q;
            c_OP_NOR: res_d = ~(s1_a_q | s1_b_q);
            c_OP_ADD, c_OP_SUB: begin
                res_d = sum[WIDTH-1:0];
                cy_d  = sum[WIDTH];
                ov_d  = ovf;
            end
            c_OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default:  legal = 1'b0;
        endcase
        z_d   = legal && (res_d == '0);
        wb_en = s1_vld_q && legal;
    end

`ifdef PIPEALU_PARAM_FWD_EN
    always_comb begin
        a_d      = (wb_en && (s1_rd_q == rs_in)) ? res_d : regs_q[rs_in];
        b_d      = (wb_en && (s1_rd_q == rt_in)) ? res_d : regs_q[rt_in];
        in_ready = rdy_q;
    end
`else
    logic hazard;
    always_comb begin
        a_d      = regs_q[rs_in];
        b_d      = regs_q[rt_in];
        hazard   = wb_en && ((s1_rd_q == rs_in) || (s1_rd_q == rt_in));
        in_ready = rdy_q && !hazard;
    end
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q    <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_op_q  <= '0;
            s1_rd_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            vld_q    <= 1'b0;
            res_q    <= '0;
            rd_q     <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            o_q      <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            s1_vld_q <= accept;
            if (accept) begin
                s1_op_q <= op_in;
                s1_rd_q <= rd_in;
                s1_a_q  <= a_d;
                s1_b_q  <= b_d;
            end
            vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                res_q <= res_d;
                rd_q  <= s1_rd_q;
                z_q   <= z_d;
                c_q   <= cy_d;
                o_q   <= ov_d;
            end
        end
    end

    // Write-back is assigned after the load so it wins on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (ld_en) regs_q[ld_addr] <= ld_data;
            if (wb_en) regs_q[s1_rd_q] <= res_d;
        end
    end

    assign out_valid = vld_q;
    assign AluOut    = res_q;
    assign out_rd    = rd_q;
    assign Zero      = z_q;
    assign Carryout  = c_q;
    assign Overflow  = o_q;

endmodule

`default_nettype wire
